// File: rtl/ntt_addr_sched.sv
// ntt_addr_sched
// Address scheduler for an in-place radix-2 Cooley-Tukey NTT over a
// dual-port coefficient RAM. Walks LOGN stages of N/2 butterflies and issues
// a read pair plus twiddle index for each butterfly. The write-back pair is
// the read pair delayed by PIPE enabled cycles. PIPE idle cycles are inserted
// between stages so the next stage never reads a coefficient that is still
// in flight.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      synchronous active-high reset
//   i_start    run request, honoured only in IDLE with i_hold=0
//   i_hold     global stall, freezes all state and masks the strobes
//   o_busy     transform in progress
//   o_done     completion pulse (stretched while held)
//   o_rd_en    read strobe for the coefficient pair
//   o_rd_addr  {a, b} read pair
//   o_tw_idx   twiddle ROM index, valid with o_rd_en
//   o_wr_en    write-back strobe
//   o_wr_addr  {a, b} write-back pair
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | waiting for i_start
// S_ISSUE | one butterfly read per cycle, k = 0 .. N/2-1
// S_DRAIN | PIPE cycles without reads, lets writes land
// S_DONE  | o_done asserted, back to IDLE on next enabled edge

module ntt_addr_sched #(
   parameter int LOGN = 9,
   parameter int AW   = 9,
   parameter int PIPE = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_hold,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [2*AW-1:0]   o_rd_addr,
   output logic [AW-1:0]     o_tw_idx,
   output logic              o_wr_en,
   output logic [2*AW-1:0]   o_wr_addr
);

   localparam int KW = LOGN - 1;
   localparam int SW = $clog2(LOGN);
   localparam int DW = $clog2(PIPE) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_nxt_state;
   logic [SW-1:0]     r_stage;
   logic [SW-1:0]     w_nxt_stage;
   logic [KW-1:0]     r_k;
   logic [KW-1:0]     w_nxt_k;
   logic [DW-1:0]     r_drain;
   logic [DW-1:0]     w_nxt_drain;

   logic              r_rd_en;
   logic [2*AW-1:0]   r_rd_addr;
   logic [AW-1:0]     r_tw_idx;

   logic [PIPE-1:0]   r_dl_vld;
   logic [2*AW-1:0]   r_dl_addr [PIPE];

   logic [SW-1:0]     w_sh;
   logic [AW-1:0]     w_m;
   logic [AW-1:0]     w_g;
   logic [AW-1:0]     w_j;
   logic [AW-1:0]     w_a;
   logic [AW-1:0]     w_b;
   logic [AW-1:0]     w_tw;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_stage = r_stage;
      w_nxt_k     = r_k;
      w_nxt_drain = r_drain;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_nxt_state = S_ISSUE;
               w_nxt_stage = '0;
               w_nxt_k     = '0;
            end
         end
         S_ISSUE: begin
            if (r_k == '1) begin
               w_nxt_state = S_DRAIN;
               w_nxt_drain = '0;
            end else begin
               w_nxt_k = r_k + KW'(1);
            end
         end
         S_DRAIN: begin
            if (r_drain == DW'(PIPE - 1)) begin
               if (r_stage == SW'(LOGN - 1)) begin
                  w_nxt_state = S_DONE;
               end else begin
                  w_nxt_state = S_ISSUE;
                  w_nxt_stage = r_stage + SW'(1);
                  w_nxt_k     = '0;
               end
            end else begin
               w_nxt_drain = r_drain + DW'(1);
            end
         end
         S_DONE: begin
            w_nxt_state = S_IDLE;
         end
         default: begin
            w_nxt_state = S_IDLE;
         end
      endcase
   end

   // Address for the butterfly about to be issued, computed from the next
   // counter values so the registered outputs line up with the ISSUE state.
   // Half-span m = 1 << sh, group g = k >> sh, offset j = k mod m.
   always_comb begin
      w_sh = SW'(LOGN - 1) - w_nxt_stage;
      w_m  = AW'(1) << w_sh;
      w_g  = AW'(w_nxt_k) >> w_sh;
      w_j  = AW'(w_nxt_k) & (w_m - AW'(1));
      w_a  = (w_g << (w_sh + SW'(1))) | w_j;
      w_b  = w_a + w_m;
      w_tw = (AW'(1) << w_nxt_stage) + w_g;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_stage   <= '0;
         r_k       <= '0;
         r_drain   <= '0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_tw_idx  <= '0;
         r_dl_vld  <= '0;
         for (int i = 0; i < PIPE; i++) begin
            r_dl_addr[i] <= '0;
         end
      end else if (!i_hold) begin
         r_state  <= w_nxt_state;
         r_stage  <= w_nxt_stage;
         r_k      <= w_nxt_k;
         r_drain  <= w_nxt_drain;
         r_rd_en  <= (w_nxt_state == S_ISSUE);
         if (w_nxt_state == S_ISSUE) begin
            r_rd_addr <= {w_a, w_b};
            r_tw_idx  <= w_tw;
         end
         // The delay line advances only on enabled cycles, so a held
         // pipeline resumes its pending writes in order.
         r_dl_vld     <= {r_dl_vld[PIPE-2:0], r_rd_en};
         r_dl_addr[0] <= r_rd_addr;
         for (int i = 1; i < PIPE; i++) begin
            r_dl_addr[i] <= r_dl_addr[i-1];
         end
      end
   end

   assign o_busy    = (r_state != S_IDLE);
   assign o_done    = (r_state == S_DONE);
   assign o_rd_en   = r_rd_en & ~i_hold;
   assign o_rd_addr = r_rd_addr;
   assign o_tw_idx  = r_tw_idx;
   assign o_wr_en   = r_dl_vld[PIPE-1] & ~i_hold;
   assign o_wr_addr = r_dl_addr[PIPE-1];

endmodule

// File: tb/tb_ntt_addr_sched.sv
// tb_ntt_addr_sched
// Self-checking bench for ntt_addr_sched. A reference model tracks a
// "virtual time" (enabled cycles since start) and derives every expected
// output from the butterfly formulas; one compare process checks the DUT
// against it on every cycle.

module tb_ntt_addr_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        hold;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [17:0] rd_addr;
   logic [8:0]  tw_idx;
   logic        wr_en;
   logic [17:0] wr_addr;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_valid   = 1'b0;
   bit m_running = 1'b0;
   bit m_fresh   = 1'b0;
   int m_v       = 0;
   int m_cyc     = 0;
   int done_at   = -1;
   int n_rd      = 0;
   int n_wr      = 0;
   int wr_cnt [512];
   logic prev_done = 1'b0;

   localparam int T_DONE = 2377;

   always #5 clk = ~clk;

   ntt_addr_sched #(.LOGN(9), .AW(9), .PIPE(8)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_hold    (hold),
      .o_busy    (busy),
      .o_done    (done),
      .o_rd_en   (rd_en),
      .o_rd_addr (rd_addr),
      .o_tw_idx  (tw_idx),
      .o_wr_en   (wr_en),
      .o_wr_addr (wr_addr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // virtual time v: stage s reads at v = 1+264s .. 256+264s
   function automatic bit is_read(input int v);
      if (v < 1) return 1'b0;
      return ((v - 1) / 264 < 9) && ((v - 1) % 264 < 256);
   endfunction

   function automatic void exp_addr(input int v, output logic [17:0] addr, output logic [8:0] tw);
      int s, k, m, g, j, a, b;
      s = (v - 1) / 264;
      k = (v - 1) % 264;
      m = 256 >> s;
      g = k / m;
      j = k % m;
      a = g * 2 * m + j;
      b = a + m;
      addr = {9'(a), 9'(b)};
      tw   = 9'((1 << s) + g);
   endfunction

   logic [17:0] e_addr;
   logic [8:0]  e_tw;
   logic        e_rd;
   logic        e_wr;
   int          e_stage;

   always @(negedge clk) begin
      if (m_valid) begin
         e_rd = m_running && !hold && is_read(m_v);
         e_wr = m_running && !hold && is_read(m_v - 8);
         chk("busy",  busy,  m_running);
         chk("done",  done,  m_running && (m_v == T_DONE));
         chk("rd_en", rd_en, e_rd);
         chk("wr_en", wr_en, e_wr);
         if (e_rd) begin
            exp_addr(m_v, e_addr, e_tw);
            chk("rd_addr", rd_addr, e_addr);
            chk("tw_idx",  tw_idx,  e_tw);
            e_stage = (m_v - 1) / 264;
            chk("hazard_a", wr_cnt[rd_addr[17:9]], e_stage);
            chk("hazard_b", wr_cnt[rd_addr[8:0]],  e_stage);
            case (m_v)
               1: begin
                  chk("pin_s0_first_addr", rd_addr, {9'd0, 9'd256});
                  chk("pin_s0_first_tw",   tw_idx,  9'd1);
               end
               256: begin
                  chk("pin_s0_last_addr", rd_addr, {9'd255, 9'd511});
                  chk("pin_s0_last_tw",   tw_idx,  9'd1);
               end
               393: begin
                  chk("pin_s1_k128_addr", rd_addr, {9'd256, 9'd384});
                  chk("pin_s1_k128_tw",   tw_idx,  9'd3);
               end
               2113: begin
                  chk("pin_s8_first_addr", rd_addr, {9'd0, 9'd1});
                  chk("pin_s8_first_tw",   tw_idx,  9'd256);
               end
               2368: begin
                  chk("pin_s8_last_addr", rd_addr, {9'd510, 9'd511});
                  chk("pin_s8_last_tw",   tw_idx,  9'd511);
               end
               default: ;
            endcase
         end
         if (e_wr) begin
            exp_addr(m_v - 8, e_addr, e_tw);
            chk("wr_addr", wr_addr, e_addr);
            if (m_v == 9) chk("pin_first_wr_addr", wr_addr, {9'd0, 9'd256});
         end
         if (m_fresh) begin
            chk("rst_rd_addr", rd_addr, 18'd0);
            chk("rst_wr_addr", wr_addr, 18'd0);
            chk("rst_tw_idx",  tw_idx,  9'd0);
         end
         if (rd_en === 1'b1) n_rd++;
         if (wr_en === 1'b1) begin
            n_wr++;
            wr_cnt[wr_addr[17:9]]++;
            wr_cnt[wr_addr[8:0]]++;
         end
         if (done === 1'b1 && prev_done !== 1'b1 && done_at < 0) done_at = m_cyc;
      end
      prev_done = done;

      // advance the model across the coming edge
      if (rst) begin
         m_valid   = 1'b1;
         m_running = 1'b0;
         m_fresh   = 1'b1;
         m_v       = 0;
      end else if (m_valid) begin
         if (m_running) begin
            m_cyc++;
            if (!hold) begin
               m_v++;
               if (m_v > T_DONE) m_running = 1'b0;
            end
         end else if (start && !hold) begin
            m_running = 1'b1;
            m_fresh   = 1'b0;
            m_v       = 1;
            m_cyc     = 1;
            done_at   = -1;
            n_rd      = 0;
            n_wr      = 0;
            for (int i = 0; i < 512; i++) wr_cnt[i] = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: random start pulses while busy
   // mode 1: hold for cycles 100..104
   // mode 2: random holds, plus a stretched hold while done is up
   task automatic run_full(input int mode, input string tag);
      int held;
      int dh;
      int c;
      held = 0;
      dh   = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 1;
      for (int i = 0; i < 8000 && m_running; i++) begin
         hold  = 1'b0;
         start = ($urandom_range(0, 15) == 0);
         if (mode == 1) hold = (c >= 100 && c <= 104);
         if (mode == 2) begin
            hold = ($urandom_range(0, 7) == 0);
            if (m_v == T_DONE && dh < 3) begin
               hold = 1'b1;
               dh++;
            end
         end
         if (hold && m_v < T_DONE) held++;
         tick();
         c++;
      end
      start = 1'b0;
      hold  = 1'b0;
      chk({tag, "_timeout"}, m_running, 1'b0);
      chk({tag, "_done_at"}, done_at, T_DONE + held);
      if (mode == 1) chk({tag, "_done_at_2382"}, done_at, 2382);
      chk({tag, "_reads"},  n_rd, 2304);
      chk({tag, "_writes"}, n_wr, 2304);
      repeat (4) tick();
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      hold  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (20) tick();

      run_full(0, "plain");
      run_full(1, "hold100");

      // start together with hold in IDLE must not be latched
      hold  = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      hold  = 1'b0;
      repeat (5) tick();
      chk("start_hold_ignored", busy, 1'b0);

      // reset in the middle of a run
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (499) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (30) tick();
      chk("abort_no_done", done_at, -1);
      chk("abort_idle", busy, 1'b0);

      run_full(0, "after_rst");
      run_full(2, "rand_hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
